tag_fa_miss_controller: RTL
===========================

Name: tag_fa_miss_controller

Overview:
Sequencer in front of the fully-associative tag lookup table; the table's `*_i` ports are driven by this block's `tbl_*_o` outputs.
- Accepts one block-address request at a time and searches the table.
- On a hit, returns the cache slot.
- On a miss, picks a victim slot by round-robin, evicts it if it is valid, fetches the new block, installs the tag and returns the slot.
- Owns the table's wren/rmen/cache_addr strobes, so no other agent writes the table.

Parameters:
BW_ACCESS_ADDR, 32, access address width (word-granular)
N_WORDS_PER_BLOCK, 8, words per block; power of two
N_CAPACITY_BLOCKS, 16, table entries; power of two, >=2

Ports:
clock_i  in  1  clock
reset_i  in  1  synchronous reset, active-high
req_valid_i  in  1  request strobe
req_addr_i  in  BW_ACCESS_ADDR  requested access address
req_ready_o  out  1  high only in IDLE
resp_valid_o  out  1  one-cycle response pulse
resp_hit_o  out  1  1 = hit, 0 = serviced miss
resp_cache_addr_o  out  BW_CAPACITY_BLOCKS  slot holding the block
tbl_search_addr_o  out  BW_ACCESS_ADDR  drives table access_addr_search_i
tbl_hit_i  in  1  table hit_o
tbl_cache_addr_i  in  BW_CAPACITY_BLOCKS  table cache_addr_search_o
tbl_victim_addr_i  in  BW_ACCESS_ADDR  table access_addr_search_o (readback of tbl_cache_addr_o)
tbl_cache_addr_o  out  BW_CAPACITY_BLOCKS  table cache_addr_i
tbl_write_addr_o  out  BW_ACCESS_ADDR  table access_addr_write_i
tbl_wren_o  out  1  table wren_i
tbl_rmen_o  out  1  table rmen_i
evict_req_o  out  1  evict request, held until ack
evict_addr_o  out  BW_ACCESS_ADDR  block address being evicted (offset bits zero)
evict_ack_i  in  1  evict done
fill_req_o  out  1  fill request, held until ack
fill_addr_o  out  BW_ACCESS_ADDR  block-aligned fill address
fill_ack_i  in  1  fill done

Behaviour:
- Clock and reset: one clock, clock_i; reset reset_i is synchronous and active-high. The table's own reset is tied externally and is not driven here.
- Reset values: state IDLE; all outputs 0 except req_ready_o = 1; victim pointer 0; fill count 0.
- req_addr_i is latched block-aligned (low CLOG2(N_WORDS_PER_BLOCK) bits zeroed) when req_valid_i && req_ready_o. req_valid_i outside IDLE is ignored.
- States:
  - IDLE: on accept, go to LOOKUP.
  - LOOKUP: tbl_search_addr_o = latched address; sample tbl_hit_i and tbl_cache_addr_i combinationally.
    - Hit: go to RESPOND with resp_hit = 1.
    - Miss and fill count < N_CAPACITY_BLOCKS: victim = fill count; go to FILL.
    - Miss and table full: victim = pointer; go to EVICT.
  - EVICT: tbl_cache_addr_o = victim; evict_addr_o = tbl_victim_addr_i (registered on entry). evict_req_o stays high until evict_ack_i is sampled. Then pulse tbl_rmen_o for 1 cycle and go to FILL.
  - FILL: fill_req_o and fill_addr_o held until fill_ack_i is sampled; then go to INSTALL.
  - INSTALL: tbl_wren_o = 1 for exactly 1 cycle, with tbl_cache_addr_o = victim and tbl_write_addr_o = latched address.
    - If the table was not full, increment the fill count.
    - If it was full, pointer = pointer + 1, wrapping mod N_CAPACITY_BLOCKS.
    - Go to RESPOND with resp_hit = 0.
  - RESPOND: resp_valid_o = 1 for 1 cycle; return to IDLE.
- Latency from accept:
  - Hit: resp_valid_o 2 cycles later.
  - Cold miss: 4 + fill wait cycles.
  - Full miss: 6 + evict wait + fill wait cycles.
- An ack arriving in the same cycle as the request's first assertion is accepted; 0-wait acks are legal. Acks outside their state are ignored.
- tbl_wren_o and tbl_rmen_o are never high in the same cycle.
- reset_i mid-transaction: abort immediately to IDLE, no response, and all req/strobe outputs go low the next cycle.
- Fill count saturates at N_CAPACITY_BLOCKS. The pointer is unused until the table is full.

Optional Feature:
TAG_FA_MISS_CTRL_STATS_EN
- Defined: 32-bit saturating counters stat_hits_o and stat_misses_o, incremented in RESPOND and cleared by reset_i.
- Undefined: both ports are present and tied to 0, so the port list is unchanged.

Decomposition:
- Package tag_fa_ctrl_pkg holds:
  - state enum (IDLE, LOOKUP, EVICT, FILL, INSTALL, RESPOND);
  - derived widths BW_CAPACITY_BLOCKS and BW_WORDS_PER_BLOCK via CLOG2;
  - stats counter width.
- Sub-module tag_fa_victim_sel contains the fill counter, round-robin pointer, full flag and victim output. It takes an advance strobe on INSTALL.

Test Plan:
1. Reset, then request 0x40 with tbl_hit_i = 0 and fill_ack_i one cycle after fill_req_o -> tbl_wren_o once with slot 0, resp_valid_o with resp_hit_o = 0 and slot 0; fill count = 1.
2. Request 0x44 with tbl_hit_i = 1 and tbl_cache_addr_i = 0 -> resp_valid_o 2 cycles after accept, hit = 1, slot 0; no wren, rmen or fill.
3. Fill all 16 slots, then miss 0x800 with tbl_victim_addr_i = 0x40 -> evict_addr_o = 0x40, rmen pulse at slot 0, fill_addr_o = 0x800, wren at slot 0; pointer becomes 1.
4. 16 further full misses -> victims are slots 1..15 then 0 (wrap), one evict per miss.
5. Assert reset_i during FILL with fill_req_o high -> next cycle req_ready_o = 1, fill_req_o = 0, no resp_valid_o, pointer and count = 0.
6. Hold req_valid_i high during a busy miss -> only one response; the second request is accepted only after RESPOND. With STATS_EN, hits = 0 and misses = 1.

Source files
------------

// File: rtl/tag_fa_ctrl_pkg.sv
// tag_fa_ctrl_pkg: state encoding, default geometry, derived widths and stats helper for the FA tag miss controller
package tag_fa_ctrl_pkg;
   localparam int DEF_BW_ACCESS_ADDR    = 32;
   localparam int DEF_N_WORDS_PER_BLOCK = 8;
   localparam int DEF_N_CAPACITY_BLOCKS = 16;
   localparam int BW_CAPACITY_BLOCKS    = $clog2(DEF_N_CAPACITY_BLOCKS);
   localparam int BW_WORDS_PER_BLOCK    = $clog2(DEF_N_WORDS_PER_BLOCK);
   localparam int STAT_W                = 32;
   typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, FILL, INSTALL, RESPOND} state_e;
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return &v ? v : v + STAT_W'(1);
   endfunction
endpackage

// File: rtl/tag_fa_victim_sel.sv
// tag_fa_victim_sel: cold-fill counter and round-robin pointer that choose the replacement slot
module tag_fa_victim_sel
   import tag_fa_ctrl_pkg::*;
#(
   parameter int N_CAPACITY_BLOCKS = DEF_N_CAPACITY_BLOCKS
) (
   input  logic                                 clock_i,
   input  logic                                 reset_i,
   input  logic                                 advance_i,
   output logic [$clog2(N_CAPACITY_BLOCKS)-1:0] victim_o,
   output logic                                 full_o
);
   localparam int CB = $clog2(N_CAPACITY_BLOCKS);
   localparam int CW = CB + 1;
   logic [CW-1:0] count_q, count_d;
   logic [CB-1:0] ptr_q, ptr_d;
   // unused slots are handed out in order; once all are used the pointer rotates
   always_comb begin
      full_o   = count_q == CW'(N_CAPACITY_BLOCKS);
      victim_o = full_o ? ptr_q : count_q[CB-1:0];
      count_d  = (advance_i && !full_o) ? count_q + CW'(1) : count_q;
      ptr_d    = (advance_i && full_o) ? ptr_q + CB'(1) : ptr_q;
   end
   // fill count and round-robin pointer registers
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         count_q <= '0;
         ptr_q   <= '0;
      end else begin
         count_q <= count_d;
         ptr_q   <= ptr_d;
      end
   end
endmodule

// File: rtl/tag_fa_miss_controller.sv
// tag_fa_miss_controller: sequences lookup/evict/fill/install on the FA tag table; TAG_FA_MISS_CTRL_STATS_EN adds hit/miss counters
module tag_fa_miss_controller
   import tag_fa_ctrl_pkg::*;
#(
   parameter int BW_ACCESS_ADDR    = DEF_BW_ACCESS_ADDR,
   parameter int N_WORDS_PER_BLOCK = DEF_N_WORDS_PER_BLOCK,
   parameter int N_CAPACITY_BLOCKS = DEF_N_CAPACITY_BLOCKS
) (
   input  logic                                 clock_i,
   input  logic                                 reset_i,
   input  logic                                 req_valid_i,
   input  logic [BW_ACCESS_ADDR-1:0]            req_addr_i,
   output logic                                 req_ready_o,
   output logic                                 resp_valid_o,
   output logic                                 resp_hit_o,
   output logic [$clog2(N_CAPACITY_BLOCKS)-1:0] resp_cache_addr_o,
   output logic [BW_ACCESS_ADDR-1:0]            tbl_search_addr_o,
   input  logic                                 tbl_hit_i,
   input  logic [$clog2(N_CAPACITY_BLOCKS)-1:0] tbl_cache_addr_i,
   input  logic [BW_ACCESS_ADDR-1:0]            tbl_victim_addr_i,
   output logic [$clog2(N_CAPACITY_BLOCKS)-1:0] tbl_cache_addr_o,
   output logic [BW_ACCESS_ADDR-1:0]            tbl_write_addr_o,
   output logic                                 tbl_wren_o,
   output logic                                 tbl_rmen_o,
   output logic                                 evict_req_o,
   output logic [BW_ACCESS_ADDR-1:0]            evict_addr_o,
   input  logic                                 evict_ack_i,
   output logic                                 fill_req_o,
   output logic [BW_ACCESS_ADDR-1:0]            fill_addr_o,
   input  logic                                 fill_ack_i,
   output logic [STAT_W-1:0]                    stat_hits_o,
   output logic [STAT_W-1:0]                    stat_misses_o
);
   localparam int CB = $clog2(N_CAPACITY_BLOCKS);
   localparam int WB = $clog2(N_WORDS_PER_BLOCK);
   localparam logic [BW_ACCESS_ADDR-1:0] BLK_MASK = ~((BW_ACCESS_ADDR'(1) << WB) - BW_ACCESS_ADDR'(1));
   state_e                  state_q, state_d;
   logic [BW_ACCESS_ADDR-1:0] addr_q, addr_d, evict_addr_q, evict_addr_d;
   logic                    rm_q, rm_d, hit_q, hit_d;
   logic [CB-1:0]           slot_q, slot_d, victim;
   logic                    full;
   tag_fa_victim_sel #(.N_CAPACITY_BLOCKS(N_CAPACITY_BLOCKS)) u_victim (
      .clock_i  (clock_i),
      .reset_i  (reset_i),
      .advance_i(state_q == INSTALL),
      .victim_o (victim),
      .full_o   (full)
   );
   // next state; rm_q marks the single rmen cycle that closes an eviction
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      evict_addr_d = evict_addr_q;
      rm_d         = rm_q;
      hit_d        = hit_q;
      slot_d       = slot_q;
      case (state_q)
         IDLE: if (req_valid_i) begin
            addr_d  = req_addr_i & BLK_MASK;
            state_d = LOOKUP;
         end
         LOOKUP: begin
            hit_d   = tbl_hit_i;
            slot_d  = tbl_hit_i ? tbl_cache_addr_i : victim;
            rm_d    = 1'b0;
            state_d = tbl_hit_i ? RESPOND : full ? EVICT : FILL;
            if (!tbl_hit_i && full) evict_addr_d = tbl_victim_addr_i & BLK_MASK;
         end
         EVICT: begin
            rm_d    = rm_q ? 1'b0 : evict_ack_i;
            state_d = rm_q ? FILL : EVICT;
         end
         FILL:    state_d = fill_ack_i ? INSTALL : FILL;
         INSTALL: state_d = RESPOND;
         RESPOND: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // controller registers
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         evict_addr_q <= '0;
         rm_q         <= 1'b0;
         hit_q        <= 1'b0;
         slot_q       <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         evict_addr_q <= evict_addr_d;
         rm_q         <= rm_d;
         hit_q        <= hit_d;
         slot_q       <= slot_d;
      end
   end
   assign req_ready_o       = state_q == IDLE;
   assign resp_valid_o      = state_q == RESPOND;
   assign resp_hit_o        = resp_valid_o & hit_q;
   assign resp_cache_addr_o = resp_valid_o ? slot_q : '0;
   assign tbl_search_addr_o = addr_q;
   assign tbl_write_addr_o  = addr_q;
   assign tbl_cache_addr_o  = victim;
   assign tbl_wren_o        = state_q == INSTALL;
   assign tbl_rmen_o        = state_q == EVICT && rm_q;
   assign evict_req_o       = state_q == EVICT && !rm_q;
   assign evict_addr_o      = evict_addr_q;
   assign fill_req_o        = state_q == FILL;
   assign fill_addr_o       = addr_q;
`ifdef TAG_FA_MISS_CTRL_STATS_EN
   logic [STAT_W-1:0] hits_q, hits_d, misses_q, misses_d;
   // saturating tallies bumped once per response
   always_comb begin
      hits_d   = (state_q == RESPOND && hit_q) ? sat_inc(hits_q) : hits_q;
      misses_d = (state_q == RESPOND && !hit_q) ? sat_inc(misses_q) : misses_q;
   end
   // stats registers
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         hits_q   <= '0;
         misses_q <= '0;
      end else begin
         hits_q   <= hits_d;
         misses_q <= misses_d;
      end
   end
   assign stat_hits_o   = hits_q;
   assign stat_misses_o = misses_q;
`else
   assign stat_hits_o   = '0;
   assign stat_misses_o = '0;
`endif
endmodule
